// File: rtl/trap_ctrl_pkg.sv
// Shared trap constants: FSM states, default vectors and trap_cause layout.
// The ID-stage decoder imports the same vector constants.
package trap_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_KERNEL  = 2'd0,
        ST_USER    = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_e;

    localparam logic [31:0] IRQ_VEC_DEF = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC_DEF = 32'h8000_0008;

    localparam int CAUSE_W       = 4;
    localparam int CAUSE_EXC_BIT = 2;

    // Layout is {src[2], is_exc, src[1:0]} so NSRC<=4 keeps bit 3 clear.
    function automatic logic [CAUSE_W-1:0] mk_cause(input logic is_exc, input logic [2:0] src);
        return {src[2], is_exc, src[1:0]};
    endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Bundle between the pipeline (ID/IF stages and interrupt sources) and trap_ctrl.
interface trap_ctrl_if #(
    parameter int NSRC = 4
);
    logic [NSRC-1:0] irq_req;
    logic [NSRC-1:0] irq_mask;
    logic            id_valid;
    logic [31:0]     id_pc;
    logic            id_except;
    logic            id_stall;
    logic            ex_redirect;

    logic            trap_take;
    logic            trap_valid;
    logic [31:0]     trap_vector;
    logic            flush_if;
    logic [NSRC-1:0] irq_ack;
    logic [3:0]      trap_cause;
    logic            in_kernel;
    logic            exc_in_kern;

    modport master (
        output irq_req, irq_mask, id_valid, id_pc, id_except, id_stall, ex_redirect,
        input  trap_take, trap_valid, trap_vector, flush_if, irq_ack, trap_cause,
               in_kernel, exc_in_kern
    );

    modport slave (
        input  irq_req, irq_mask, id_valid, id_pc, id_except, id_stall, ex_redirect,
        output trap_take, trap_valid, trap_vector, flush_if, irq_ack, trap_cause,
               in_kernel, exc_in_kern
    );
endinterface

// File: rtl/trap_ctrl_prio_enc.sv
// Lowest-index-wins priority encoder over the pending interrupt sources.
module trap_prio_enc #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    output logic          vld_o,
    output logic [IW-1:0] idx_o
);

    // Scan from the top so the lowest set bit is the last writer.
    always_comb begin
        vld_o = 1'b0;
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                vld_o = 1'b1;
                idx_o = IW'(i);
            end
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Interrupt/exception entry and kernel-exit sequencing beside the ID-stage decoder.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int          NSRC    = 4,
    parameter int          HOLDOFF = 2,
    parameter logic [31:0] IRQ_VEC = IRQ_VEC_DEF,
    parameter logic [31:0] EXC_VEC = EXC_VEC_DEF
) (
    input  logic       clk,
    input  logic       reset,
    trap_ctrl_if.slave bus
);

    localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int CW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic            in_kernel_q;
    logic [NSRC-1:0] irq_ack_q;
    logic [3:0]      trap_cause_q;
    logic            exc_in_kern_q;

    logic            q_slot;
    logic            leave_kern;
    logic [NSRC-1:0] pend;
    logic            pend_vld;
    logic [IW-1:0]   pend_idx;
    logic [2:0]      src_ext;
    logic            take_exc;
    logic            take_irq;
    logic            take;
    logic [31:0]     vector;
    logic            pc_unused;

    assign pc_unused = ^bus.id_pc[30:0];

    // Kernel exit ignores ex_redirect: a user slot advancing out of ID ends kernel mode.
    assign q_slot     = bus.id_valid & ~bus.id_stall & ~bus.ex_redirect & ~bus.id_pc[31];
    assign leave_kern = bus.id_valid & ~bus.id_stall & ~bus.id_pc[31];

    assign pend = bus.irq_req & ~bus.irq_mask;

    trap_prio_enc #(
        .N  (NSRC),
        .IW (IW)
    ) u_prio (
        .req_i (pend),
        .vld_o (pend_vld),
        .idx_o (pend_idx)
    );

    assign src_ext = 3'(pend_idx);

    // Gating by reset makes trap_take fall immediately when reset hits mid-trap.
    assign take_exc = reset & q_slot & bus.id_except & (state_q != ST_KERNEL);
    assign take_irq = reset & q_slot & ~bus.id_except & pend_vld & (state_q == ST_USER);
    assign take     = take_exc | take_irq;

    always_comb begin
        vector = '0;
        if (take_exc)      vector = EXC_VEC;
        else if (take_irq) vector = IRQ_VEC;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_KERNEL;
            cnt_q         <= '0;
            in_kernel_q   <= 1'b1;
            irq_ack_q     <= '0;
            trap_cause_q  <= '0;
            exc_in_kern_q <= 1'b0;
        end else begin
            irq_ack_q <= '0;
            if (take) begin
                state_q      <= ST_KERNEL;
                in_kernel_q  <= 1'b1;
                cnt_q        <= '0;
                trap_cause_q <= mk_cause(take_exc, take_exc ? 3'd0 : src_ext);
                if (take_irq) irq_ack_q <= NSRC'(1) << pend_idx;
            end else begin
                case (state_q)
                    ST_KERNEL: begin
                        if (leave_kern) begin
                            in_kernel_q <= 1'b0;
                            if (HOLDOFF == 0) begin
                                state_q <= ST_USER;
                            end else begin
                                state_q <= ST_HOLDOFF;
                                cnt_q   <= CW'(HOLDOFF);
                            end
                        end
                    end
                    ST_HOLDOFF: begin
                        if (q_slot) begin
                            if (cnt_q == CW'(1)) state_q <= ST_USER;
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                    default: ;
                endcase
            end
            if (state_q == ST_KERNEL && bus.id_except) exc_in_kern_q <= 1'b1;
        end
    end

    assign bus.trap_take   = take;
    assign bus.trap_valid  = take;
    assign bus.flush_if    = take;
    assign bus.trap_vector = vector;
    assign bus.irq_ack     = irq_ack_q;
    assign bus.trap_cause  = trap_cause_q;
    assign bus.in_kernel   = in_kernel_q;
    assign bus.exc_in_kern = exc_in_kern_q;

endmodule
